// File: rtl/video_stream_framer_pkg.sv
// Shared types and constants for the video stream framer.
// Beat payload carried through the output skid buffer.
package video_pkg;

    localparam int VID_DATA_W = 32;
    localparam int VID_CNT_W  = 12;

    typedef struct packed {
        logic [VID_DATA_W-1:0] tdata;
        logic                  tuser;
        logic                  tlast;
    } vid_beat_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/video_stream_framer_if.sv
// AXI4-Stream video bundle with master/slave views.
// Raw DMA side leaves tuser/tlast undriven by the framer.
interface video_stream_framer_if #(
    parameter int DATA_W = video_pkg::VID_DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (
        output tdata, tvalid, tuser, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tuser, tlast,
        output tready
    );
endinterface

// File: rtl/video_stream_framer_skid.sv
// Two-entry skid buffer with registered ready and valid.
// Occupancy lives in cnt; out_data is always the head entry.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    logic [W-1:0] s1;
    logic [1:0]   cnt;
    logic [1:0]   cnt_n;
    logic         push;
    logic         pop;

    assign push = in_valid;
    assign pop  = out_valid & out_ready;

    always_comb begin
        cnt_n = cnt;
        if (push && !pop)
            cnt_n = cnt + 2'd1;
        else if (pop && !push)
            cnt_n = cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            s1        <= '0;
        end else begin
            cnt       <= cnt_n;
            out_valid <= (cnt_n != 2'd0);
            in_ready  <= en && (cnt_n < 2'd2);
            if (pop) begin
                if (cnt == 2'd2) begin
                    out_data <= s1;
                    if (push)
                        s1 <= in_data;
                end else if (push) begin
                    out_data <= in_data;
                end
            end else if (push) begin
                if (cnt == 2'd0)
                    out_data <= in_data;
                else
                    s1 <= in_data;
            end
        end
    end
endmodule

// File: rtl/video_stream_framer.sv
// Frames a raw DMA word stream into AXI4-Stream video with
// tuser at frame start and tlast at end of each line.
module video_stream_framer
    import video_pkg::*;
#(
    parameter int DATA_W = VID_DATA_W,
    parameter int CNT_W  = VID_CNT_W
) (
    input  logic                  m_axis_vid_aclk,
    input  logic                  m_axis_vid_areset,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      hres_words,
    input  logic [CNT_W-1:0]      vres_lines,
    video_stream_framer_if.slave  s_axis_raw,
    video_stream_framer_if.master m_axis_vid,
    output logic                  frame_done,
    output logic                  cfg_error,
    output logic [CNT_W-1:0]      cur_line
);
    state_t           state, state_n;
    logic [CNT_W-1:0] x, x_n, y, y_n;
    logic [CNT_W-1:0] h, h_n, v, v_n;
    logic             err_n, done_n, start;
    logic             accept, x_end, y_end;
    logic             rdy;
    logic [DATA_W-1:0] raw_data;
    vid_beat_t        in_beat, out_beat;

    assign raw_data = s_axis_raw.tdata;
    assign accept   = s_axis_raw.tvalid & rdy;
    assign x_end    = (x == h - CNT_W'(1));
    assign y_end    = (y == v - CNT_W'(1));

    assign in_beat.tdata = raw_data;
    assign in_beat.tuser = (x == '0) && (y == '0);
    assign in_beat.tlast = x_end;

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        h_n     = h;
        v_n     = v;
        err_n   = cfg_error;
        done_n  = 1'b0;
        start   = 1'b0;
        unique case (state)
            IDLE: start = enable;
            RUN: begin
                if (accept) begin
                    if (x_end) begin
                        x_n = '0;
                        if (y_end) begin
                            y_n    = '0;
                            done_n = 1'b1;
                            start  = enable;
                            if (!enable)
                                state_n = IDLE;
                        end else begin
                            y_n = y + CNT_W'(1);
                        end
                    end else begin
                        x_n = x + CNT_W'(1);
                    end
                end
            end
        endcase
        // Sizes are only trusted after the zero check.
        if (start) begin
            h_n = hres_words;
            v_n = vres_lines;
            if (hres_words == '0 || vres_lines == '0) begin
                err_n   = 1'b1;
                state_n = IDLE;
            end else begin
                err_n   = 1'b0;
                x_n     = '0;
                y_n     = '0;
                state_n = RUN;
            end
        end
    end

    always_ff @(posedge m_axis_vid_aclk or posedge m_axis_vid_areset) begin
        if (m_axis_vid_areset) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            h          <= '0;
            v          <= '0;
            cfg_error  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            h          <= h_n;
            v          <= v_n;
            cfg_error  <= err_n;
            frame_done <= done_n;
        end
    end

    axis_skid_buffer #(
        .W($bits(vid_beat_t))
    ) u_skid (
        .clk      (m_axis_vid_aclk),
        .rst      (m_axis_vid_areset),
        .en       (state_n == RUN),
        .in_valid (accept),
        .in_data  (in_beat),
        .in_ready (rdy),
        .out_valid(m_axis_vid.tvalid),
        .out_data (out_beat),
        .out_ready(m_axis_vid.tready)
    );

    assign s_axis_raw.tready = rdy;
    assign m_axis_vid.tdata  = out_beat.tdata;
    assign m_axis_vid.tuser  = out_beat.tuser;
    assign m_axis_vid.tlast  = out_beat.tlast;
    assign cur_line          = y;
endmodule

// File: tb/tb_video_stream_framer.sv
// Random-stimulus bench for video_stream_framer against a
// word-index frame model and an expected-beat queue.
module tb_video_stream_framer;
    import video_pkg::*;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] hres = 12'd4;
    logic [CW-1:0] vres = 12'd3;
    logic          frame_done;
    logic          cfg_error;
    logic [CW-1:0] cur_line;

    video_stream_framer_if raw ();
    video_stream_framer_if vid ();

    always #5 clk = ~clk;

    video_stream_framer dut (
        .m_axis_vid_aclk  (clk),
        .m_axis_vid_areset(rst),
        .enable           (enable),
        .hres_words       (hres),
        .vres_lines       (vres),
        .s_axis_raw       (raw),
        .m_axis_vid       (vid),
        .frame_done       (frame_done),
        .cfg_error        (cfg_error),
        .cur_line         (cur_line)
    );

    int n_chk  = 0;
    int n_pass = 0;

    vid_beat_t     q[$];
    int            occ;
    bit            m_run, m_err;
    int            m_h, m_v, m_idx;
    logic [CW-1:0] e_line;
    bit            e_done, e_rdy, e_vld;
    bit            stalled;
    logic [33:0]   held;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        occ     = 0;
        m_run   = 0;
        m_err   = 0;
        m_h     = 0;
        m_v     = 0;
        m_idx   = 0;
        e_line  = '0;
        e_done  = 0;
        e_rdy   = 0;
        e_vld   = 0;
        stalled = 0;
    endtask

    // Drive one cycle, predict the following edge, then check.
    task automatic step(input int pv, input int pr);
        bit        ai, ao, start, done_nx;
        vid_beat_t b, e;
        raw.tdata  = $urandom;
        raw.tvalid = ($urandom_range(99) < pv);
        vid.tready = ($urandom_range(99) < pr);
        ai = raw.tvalid && raw.tready;
        ao = vid.tvalid && vid.tready;
        if (ao) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = q.pop_front();
                chk("tdata", vid.tdata, e.tdata);
                chk("tuser", vid.tuser, e.tuser);
                chk("tlast", vid.tlast, e.tlast);
            end
        end
        start   = 0;
        done_nx = 0;
        if (m_run && ai) begin
            b.tdata = raw.tdata;
            b.tuser = (m_idx == 0);
            b.tlast = ((m_idx % m_h) == m_h - 1);
            q.push_back(b);
            m_idx++;
            if (m_idx == m_h * m_v) begin
                done_nx = 1;
                m_idx   = 0;
                start   = enable;
                if (!enable) m_run = 0;
            end
            e_line = CW'(m_idx / m_h);
        end else if (!m_run && enable) begin
            start = 1;
        end
        if (start) begin
            m_h = int'(hres);
            m_v = int'(vres);
            if (m_h == 0 || m_v == 0) begin
                m_err = 1;
                m_run = 0;
            end else begin
                m_err  = 0;
                m_run  = 1;
                m_idx  = 0;
                e_line = '0;
            end
        end
        occ     = occ + int'(ai) - int'(ao);
        e_rdy   = m_run && (occ <= 1);
        e_vld   = (occ > 0);
        e_done  = done_nx;
        stalled = vid.tvalid && !vid.tready;
        held    = {vid.tdata, vid.tuser, vid.tlast};
        @(negedge clk);
        chk("s_tready", raw.tready, e_rdy);
        chk("m_tvalid", vid.tvalid, e_vld);
        chk("frame_done", frame_done, e_done);
        chk("cfg_error", cfg_error, m_err);
        chk("cur_line", cur_line, e_line);
        if (stalled)
            chk("hold", {vid.tdata, vid.tuser, vid.tlast}, held);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tdata", vid.tdata, 0);
        chk("rst_tvalid", vid.tvalid, 0);
        chk("rst_tuser", vid.tuser, 0);
        chk("rst_tlast", vid.tlast, 0);
        chk("rst_s_tready", raw.tready, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cfg_error", cfg_error, 0);
        chk("rst_cur_line", cur_line, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_idx(input int target, input int budget);
        int n = 0;
        while (!(m_run && m_idx == target) && n < budget) begin
            step(100, 100);
            n++;
        end
        chk("wait_idx", (m_run && m_idx == target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_run && n < budget) begin
            step(100, 100);
            n++;
        end
        chk("wait_idle", m_run, 0);
    endtask

    initial begin
        raw.tdata  = '0;
        raw.tvalid = 1'b0;
        raw.tuser  = 1'b0;
        raw.tlast  = 1'b0;
        vid.tready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 4x3 frames, full throughput
        hres   = 12'd4;
        vres   = 12'd3;
        enable = 1'b1;
        for (int i = 0; i < 30; i++) step(100, 100);

        // downstream ready pattern 1-0-0-1
        for (int i = 0; i < 48; i++)
            step(100, (i % 4 == 0 || i % 4 == 3) ? 100 : 0);

        // enable drops after word 5; frame still completes
        run_to_idx(6, 60);
        enable = 1'b0;
        for (int i = 0; i < 30; i++) step(100, 100);
        chk("idle_after_drop", m_run, 0);

        // zero width, then a valid 2x1 frame
        hres   = 12'd0;
        vres   = 12'd3;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step(100, 100);
        hres = 12'd2;
        vres = 12'd1;
        for (int i = 0; i < 20; i++) step(100, 100);

        // reset mid-line at x=2, y=1
        hres = 12'd4;
        vres = 12'd3;
        run_to_idx(0, 20);
        run_to_idx(6, 40);
        do_reset();
        for (int i = 0; i < 20; i++) step(100, 100);

        // width change mid-frame applies to the next frame
        run_to_idx(3, 40);
        hres = 12'd8;
        for (int i = 0; i < 60; i++) step(100, 100);

        // random traffic and configuration
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                enable = ($urandom_range(9) != 0);
                hres   = CW'($urandom_range(5));
                vres   = CW'($urandom_range(4));
            end
            step(int'($urandom_range(100)), int'($urandom_range(100)));
        end

        enable = 1'b0;
        hres   = 12'd4;
        vres   = 12'd3;
        wait_idle(200);
        for (int i = 0; i < 10; i++) step(0, 100);
        chk("drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/video_stream_framer.md
Name: video_stream_framer

Overview:
- Upstream neighbour of the RGB565-pair-to-RGB888 converter. Takes an unframed word stream from the framebuffer DMA read port and emits an AXI4-Stream video stream in the same format. Each 32-bit word carries two RGB565 pixels, pixel 0 in [15:0] and pixel 1 in [31:16].
- Adds tuser on the first word of every frame and tlast on the last word of every line, using programmable line and frame sizes.
- Registers all outputs through a 2-entry skid buffer so backpressure from the converter never forms a combinational path to the DMA.

Parameters:
- DATA_W, 32, stream word width (two RGB565 pixels per word).
- CNT_W, 12, width of the word and line counters and of the size inputs.

Ports:
- m_axis_vid_aclk  in  1  single clock for all logic.
- m_axis_vid_areset  in  1  asynchronous, active-high reset.
- enable  in  1  level; framing runs while high.
- hres_words  in  CNT_W  words per line (pixels/2); sampled at frame start only.
- vres_lines  in  CNT_W  lines per frame; sampled at frame start only.
- s_axis_raw_tdata  in  DATA_W  raw word from DMA.
- s_axis_raw_tvalid  in  1  raw word valid.
- s_axis_raw_tready  out  1  framer accepts raw word.
- m_axis_vid_tdata  out  DATA_W  framed word, passed through unmodified.
- m_axis_vid_tvalid  out  1  output valid.
- m_axis_vid_tready  in  1  downstream ready.
- m_axis_vid_tuser  out  1  start of frame, first word only.
- m_axis_vid_tlast  out  1  end of line.
- frame_done  out  1  one-cycle pulse when the last word of a frame is accepted at the input.
- cfg_error  out  1  sticky; set when a frame start sees hres_words==0 or vres_lines==0; cleared by reset or by a valid frame start.
- cur_line  out  CNT_W  line index of the next word to be accepted.

Behaviour:
- Reset (asynchronous, immediate):
  - all outputs go to 0, including m_axis_vid_tdata.
  - state goes to IDLE; the skid buffer empties; counters x and y go to 0.
- States:
  - IDLE: s_axis_raw_tready=0. When enable=1, perform a frame start.
  - RUN: words are accepted and framed.
- Frame start: latch hres_words into H and vres_lines into V.
  - If H==0 or V==0: set cfg_error and stay in (or return to) IDLE.
  - Otherwise: clear cfg_error, set x=0 and y=0, enter or stay in RUN.
- Input accept = s_axis_raw_tvalid & s_axis_raw_tready. On each accept:
  - Push {tdata, tuser=(x==0 && y==0), tlast=(x==H-1)} into the skid buffer.
  - If x==H-1, x wraps to 0 and y increments; otherwise x increments.
  - At x==H-1 and y==V-1: y wraps to 0, frame_done pulses in the next cycle, and a frame start is evaluated the same cycle. With enable=0 the block goes to IDLE instead.
- enable falling mid-frame has no effect until the frame completes. Frames are never truncated.
- Ready and output timing:
  - s_axis_raw_tready is registered: 1 only in RUN with the skid buffer holding 0 or 1 entries after the current cycle's push and pop.
  - Latency is 1 cycle: a word accepted in cycle N appears on m_axis_vid_* in cycle N+1 when the buffer was empty.
- Output rules:
  - m_axis_vid_tvalid stays high and tdata/tuser/tlast stay stable until m_axis_vid_tready is seen (AXI4-Stream rule).
  - Words leave in order, with no drops or duplicates.
  - A push and a pop in the same cycle leave the occupancy unchanged.
- Width: comparisons use CNT_W unsigned. H-1 and V-1 are computed after the zero check, so no wrap to all-ones is possible.
- cur_line = y.

Decomposition:
- Package video_pkg:
  - typedef vid_beat_t {tdata, tuser, tlast}.
  - constants VID_DATA_W=32 and VID_CNT_W=12.
  - state enum {IDLE, RUN}.
- Sub-module axis_skid_buffer:
  - 2-entry, parameterised on payload width.
  - registered ready and valid.
  - reused for vid_beat_t.

Test Plan:
- H=4, V=3, enable=1, continuous valid, tready=1 -> 12 words in order; tuser only on word 0; tlast on words 3, 7, 11; frame_done pulses once; second frame starts with tuser on word 12.
- Same config with m_axis_vid_tready toggling 1-0-0-1 -> no loss or duplicate; outputs held stable while stalled; s_axis_raw_tready drops within 1 cycle once the buffer is full.
- enable falls after word 5 of a 4x3 frame -> words 6..11 still framed correctly; IDLE after word 11; tready=0 thereafter.
- hres_words=0 at frame start -> cfg_error=1; tready stays 0; then hres_words=2, vres_lines=1 -> cfg_error clears; tuser and tlast both set on the 2-word frame's words 0 and 1 as appropriate.
- Reset asserted mid-line (x=2, y=1) -> all outputs 0 immediately; after release with enable=1, the first word carries tuser=1.
- hres_words changed mid-frame from 4 to 8 -> current frame keeps tlast every 4 words; next frame uses 8.
